instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch unit on the far side of the controller's fetch handshake. It owns the program counter (PC) and the instruction register (IR). It responds to the controller's PC_clr, PC_up and IR_ld strobes, reads the instruction memory through a req/valid handshake, and presents the fetched 16-bit word on IR as the controller's instruction input. A bounded wait timer stops a stalled memory from hanging the processor.

Parameters:
AW, 8, PC / instruction-memory address width
DW, 16, instruction width
TIMEOUT, 15, maximum cycles to wait for IM_valid before aborting a fetch (range 1..255)
NOOP_WORD, 16'h0000, word loaded into IR when a fetch is aborted

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
PC_clr  in  1  from controller: clear PC
PC_up  in  1  from controller: increment PC
IR_ld  in  1  from controller: fetch the word at PC into IR
IM_data  in  DW  instruction memory read data
IM_valid  in  1  instruction memory: IM_data valid this cycle
IM_addr  out  AW  instruction memory address
IM_rd  out  1  instruction memory read request
IR  out  DW  instruction register, drives the controller's instruction input
IR_valid  out  1  one-cycle pulse: IR updated by a completed fetch
PC  out  AW  current program counter
Busy  out  1  fetch in progress
Fault  out  1  sticky: a fetch timed out or an IR_ld arrived while Busy

Behaviour:
- Reset low, asynchronous: PC=0, IR=0, IR_valid=0, IM_rd=0, IM_addr=0, Busy=0, Fault=0, timer=0, state=IDLE. Reset asserted mid-fetch aborts the fetch immediately. IR is not updated.
- PC update, every state, on the clock edge:
  - PC_clr=1 gives PC<=0. PC_clr has priority over PC_up.
  - Otherwise PC_up=1 gives PC<=PC+1, modulo 2^AW (8'hFF wraps to 8'h00).
- FSM states: IDLE, REQ.
- IDLE:
  - Busy=0, IM_rd=0.
  - IR_ld=1: fetch_addr<=PC (the value before any same-cycle PC_clr/PC_up), timer<=0, go to REQ.
  - A simultaneous IR_ld and PC_up therefore fetches the old PC and advances the PC; this is the normal fetch-state pattern.
- REQ:
  - Outputs: Busy=1, IM_rd=1, IM_addr=fetch_addr, all held stable until the fetch ends.
  - IM_valid=1: IR<=IM_data, IR_valid=1 in the next cycle only, go to IDLE.
  - IM_valid=0 and timer==TIMEOUT-1: IR<=NOOP_WORD, Fault<=1, IR_valid=1 next cycle, go to IDLE.
  - Otherwise timer<=timer+1.
- Latency: IR_ld sampled at edge n, IM_rd high in cycle n+1. If IM_valid is high in cycle n+1, IR changes at edge n+2 and IR_valid is high in cycle n+2. Each wait cycle adds one cycle.
- IR_ld while in REQ: ignored (no queuing), Fault<=1.
- IM_valid while in IDLE: ignored.
- IM_addr holds its last value in IDLE. IM_rd is the only qualifier.
- Fault clears only on Reset.
- Timer width: 8 bits, saturating not required because TIMEOUT is at most 255.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (IDLE=1'b0, REQ=1'b1)
  - opcode constants reused by the controller: OP_NOOP=4'h0, OP_STORE=4'h1, OP_LOAD=4'h2, OP_ADD=4'h3, OP_SUB=4'h4, OP_HALT=4'h5
  - NOOP_WORD default
- One sub-module, pc_counter: AW-bit register with clr/up priority and wrap.
- The FSM, timer and IR register stay in instr_fetch.

Test Plan:
- Reset low mid-REQ (IM_rd=1), Reset high -> all outputs 0, state IDLE, IR keeps 16'h0000, no IR_valid pulse.
- PC=8'h05, IR_ld=1 and PC_up=1 in the same cycle, memory returns IM_valid one cycle later with IM_data=16'h3123 -> IM_addr=8'h05, IR=16'h3123, IR_valid pulses once, PC=8'h06.
- PC=8'hFF, PC_up=1 -> PC=8'h00. Same cycle with PC_clr=1 and PC_up=1 at PC=8'h40 -> PC=8'h00.
- IM_valid delayed 3 cycles with IM_data=16'h5000 -> Busy high for 4 cycles, IM_rd/IM_addr stable throughout, IR=16'h5000 and IR_valid high in cycle n+5.
- IM_valid never asserted, TIMEOUT=15 -> 15 cycles of IM_rd, then IR=16'h0000, Fault=1, IR_valid pulses once, back to IDLE.
- Second IR_ld during REQ -> no new fetch, IM_addr unchanged, Fault=1. The first fetch still completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: fetch FSM encoding, opcodes, default no-op word.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  // A zero word decodes as OP_NOOP, so an aborted fetch executes harmlessly.
  localparam logic [15:0] NOOP_WORD_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_counter.sv
// Program counter: clear has priority over increment; increment wraps modulo 2^AW.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          up,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q, pc_d;

  // Next PC: clear beats increment, natural wrap on overflow.
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (up) begin
      pc_d = pc_q + AW'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC and IR, fetches through a req/valid memory
// handshake and aborts a stalled fetch after TIMEOUT request cycles.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              AW        = 8,
  parameter int              DW        = 16,
  parameter int              TIMEOUT   = 15,
  parameter logic [DW-1:0]   NOOP_WORD = DW'(NOOP_WORD_DEFAULT)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          PC_clr,
  input  logic          PC_up,
  input  logic          IR_ld,
  input  logic [DW-1:0] IM_data,
  input  logic          IM_valid,
  output logic [AW-1:0] IM_addr,
  output logic          IM_rd,
  output logic [DW-1:0] IR,
  output logic          IR_valid,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Fault
);

  // Timer counts completed wait cycles; the abort fires on the last allowed one.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [7:0]    timer_q, timer_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;

  pc_counter #(.AW(AW)) u_pc (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (PC_clr),
    .up    (PC_up),
    .pc    (PC)
  );

  // Fetch FSM next-state: latch the pre-update PC on IR_ld, then wait for data or timeout.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    timer_d      = timer_q;
    ir_d         = ir_q;
    ir_valid_d   = 1'b0;
    fault_d      = fault_q;
    case (state_q)
      IDLE: begin
        if (IR_ld) begin
          fetch_addr_d = PC;
          timer_d      = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        // No queuing: a second load request is dropped and flagged.
        if (IR_ld) begin
          fault_d = 1'b1;
        end
        if (IM_valid) begin
          ir_d       = IM_data;
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          ir_d       = NOOP_WORD;
          ir_valid_d = 1'b1;
          fault_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REQ);
  end

  // Fetch FSM state and registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      timer_q      <= '0;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      timer_q      <= timer_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
    end
  end

  assign IM_addr  = fetch_addr_q;
  assign IM_rd    = busy_q;
  assign Busy     = busy_q;
  assign IR       = ir_q;
  assign IR_valid = ir_valid_q;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_instr_fetch;

  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          PC_clr = 1'b0, PC_up = 1'b0, IR_ld = 1'b0, IM_valid = 1'b0;
  logic [DW-1:0] IM_data = '0;
  logic [AW-1:0] IM_addr, PC;
  logic          IM_rd, IR_valid, Busy, Fault;
  logic [DW-1:0] IR;

  int checks = 0;
  int failures = 0;

  instr_fetch #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .NOOP_WORD(16'h0000)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .PC_clr   (PC_clr),
    .PC_up    (PC_up),
    .IR_ld    (IR_ld),
    .IM_data  (IM_data),
    .IM_valid (IM_valid),
    .IM_addr  (IM_addr),
    .IM_rd    (IM_rd),
    .IR       (IR),
    .IR_valid (IR_valid),
    .PC       (PC),
    .Busy     (Busy),
    .Fault    (Fault)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch is "open" from the load until data arrives or
  // TIMEOUT request cycles have elapsed with no data.
  int unsigned m_pc = 0;
  int unsigned m_addr = 0;
  int unsigned m_ir = 0;
  bit          m_open = 0;
  int          m_req_cycles = 0;
  bit          m_irv = 0;
  bit          m_fault = 0;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      m_pc = 0; m_addr = 0; m_ir = 0; m_open = 0;
      m_req_cycles = 0; m_irv = 0; m_fault = 0;
    end else begin
      m_irv = 0;
      if (m_open) begin
        m_req_cycles = m_req_cycles + 1;
        if (IR_ld) m_fault = 1;
        if (IM_valid) begin
          m_ir = IM_data; m_irv = 1; m_open = 0;
        end else if (m_req_cycles == TIMEOUT) begin
          m_ir = 0; m_irv = 1; m_fault = 1; m_open = 0;
        end
      end else if (IR_ld) begin
        m_open = 1; m_addr = m_pc; m_req_cycles = 0;
      end
      if (PC_clr) m_pc = 0;
      else if (PC_up) m_pc = (m_pc + 1) % 256;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #1;
    chk("m_pc",       32'(PC),       32'(m_pc));
    chk("m_ir",       32'(IR),       32'(m_ir));
    chk("m_ir_valid", 32'(IR_valid), 32'(m_irv));
    chk("m_busy",     32'(Busy),     32'(m_open));
    chk("m_im_rd",    32'(IM_rd),    32'(m_open));
    chk("m_im_addr",  32'(IM_addr),  32'(m_addr));
    chk("m_fault",    32'(Fault),    32'(m_fault));
  end

  // One cycle of stimulus; returns shortly after the edge that samples it.
  task automatic step(input bit ld, input bit up, input bit clr, input bit vld,
                      input logic [DW-1:0] data);
    @(negedge clk);
    IR_ld = ld; PC_up = up; PC_clr = clr; IM_valid = vld; IM_data = data;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 16'h0000); endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b0;
    IR_ld = 0; PC_up = 0; PC_clr = 0; IM_valid = 0; IM_data = '0;
    #1;
    @(negedge clk);
    Reset = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    idle();
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_ir", 32'(IR), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_fault", 32'(Fault), 32'h0);

    // Reset asserted in the middle of a fetch.
    step(1, 0, 0, 0, 16'h0000);
    idle();
    chk("midreq_im_rd", 32'(IM_rd), 32'h1);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("async_im_rd", 32'(IM_rd), 32'h0);
    chk("async_busy", 32'(Busy), 32'h0);
    chk("async_ir_valid", 32'(IR_valid), 32'h0);
    @(negedge clk);
    Reset = 1'b1;
    idle();
    chk("post_rst_ir", 32'(IR), 32'h0);
    chk("post_rst_ir_valid", 32'(IR_valid), 32'h0);
    chk("post_rst_state", 32'(Busy), 32'h0);

    // Fetch at PC=5 with simultaneous increment, data one cycle later.
    repeat (5) step(0, 1, 0, 0, 16'h0000);
    chk("pc_5", 32'(PC), 32'h05);
    step(1, 1, 0, 0, 16'h0000);
    chk("f1_pc", 32'(PC), 32'h06);
    chk("f1_addr", 32'(IM_addr), 32'h05);
    chk("f1_rd", 32'(IM_rd), 32'h1);
    step(0, 0, 0, 1, 16'h3123);
    chk("f1_ir", 32'(IR), 32'h3123);
    chk("f1_irv", 32'(IR_valid), 32'h1);
    chk("f1_busy", 32'(Busy), 32'h0);
    idle();
    chk("f1_irv_drop", 32'(IR_valid), 32'h0);

    // IM_valid while idle is ignored.
    step(0, 0, 0, 1, 16'hFFFF);
    chk("idle_vld_ir", 32'(IR), 32'h3123);
    chk("idle_vld_irv", 32'(IR_valid), 32'h0);

    // Fetch with three wait cycles.
    step(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("wait_busy", 32'(Busy), 32'h1);
      chk("wait_addr", 32'(IM_addr), 32'h06);
      idle();
    end
    chk("wait_busy4", 32'(Busy), 32'h1);
    step(0, 0, 0, 1, 16'h5000);
    chk("wait_ir", 32'(IR), 32'h5000);
    chk("wait_irv", 32'(IR_valid), 32'h1);
    chk("wait_done", 32'(Busy), 32'h0);

    // PC wrap and clear priority.
    repeat (249) step(0, 1, 0, 0, 16'h0000);
    chk("pc_ff", 32'(PC), 32'hFF);
    step(0, 1, 0, 0, 16'h0000);
    chk("pc_wrap", 32'(PC), 32'h00);
    repeat (64) step(0, 1, 0, 0, 16'h0000);
    chk("pc_40", 32'(PC), 32'h40);
    step(0, 1, 1, 0, 16'h0000);
    chk("pc_clr_prio", 32'(PC), 32'h00);

    // Timeout: memory never answers.
    step(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      chk("to_rd", 32'(IM_rd), 32'h1);
      idle();
    end
    chk("to_rd_last", 32'(IM_rd), 32'h1);
    chk("to_fault_pre", 32'(Fault), 32'h0);
    idle();
    chk("to_ir", 32'(IR), 32'h0000);
    chk("to_irv", 32'(IR_valid), 32'h1);
    chk("to_fault", 32'(Fault), 32'h1);
    chk("to_idle", 32'(IM_rd), 32'h0);
    idle();
    chk("to_irv_drop", 32'(IR_valid), 32'h0);
    chk("to_fault_sticky", 32'(Fault), 32'h1);

    // Second IR_ld during a fetch.
    do_reset();
    repeat (3) step(0, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("dbl_addr0", 32'(IM_addr), 32'h03);
    step(1, 1, 0, 0, 16'h0000);
    chk("dbl_fault", 32'(Fault), 32'h1);
    chk("dbl_addr1", 32'(IM_addr), 32'h03);
    chk("dbl_pc", 32'(PC), 32'h04);
    step(0, 0, 0, 1, 16'h1234);
    chk("dbl_ir", 32'(IR), 32'h1234);
    chk("dbl_irv", 32'(IR_valid), 32'h1);
    idle();
    chk("dbl_no_refetch", 32'(Busy), 32'h0);
    chk("dbl_no_rd", 32'(IM_rd), 32'h0);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
